// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard receiver: FSM encoding, special
// scan codes and default conditioning/timeout parameters.
// No ports; imported by ps2_clk_filter and ps2_keyboard_rx.
package ps2_pkg;

  // FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // Special scan codes
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Default parameters (1 ms timeout at 50 MHz)
  localparam int PS2_FILTER_LEN_DEF = 4;
  localparam int PS2_TIMEOUT_DEF    = 50000;

endpackage

// File: rtl/ps2_clk_filter.sv
// Purpose: 2-FF synchronise ps2_clk/ps2_data, debounce the clock, flag its falling edge.
// Latency: fall_o is high 2+FILTER_LEN cycles after a clean raw falling edge; data_o is 2 cycles behind the pin.
// Backpressure: none; free-running conditioning stage.
// Ports: clock/reset (sync, active-high), ps2_clk_i/ps2_data_i raw pins,
//        fall_o one-cycle falling-edge pulse, data_o synchronised data.
module ps2_clk_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic fall_o,
  output logic data_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts consecutive synchronised samples that disagree with the
  // filtered level; the level only moves on the FILTER_LEN-th such sample.
  always_comb begin
    filt_d = filt_q;
    fall_d = 1'b0;
    cnt_d  = '0;
    if (clk_s2_q != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
        fall_d = filt_q;  // moving 1->0
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fall_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      clk_s1_q <= ps2_clk_i;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data_i;
      dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d;
      fall_q   <= fall_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fall_o = fall_q;
  assign data_o = dat_s2_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// Purpose: receive PS/2 keyboard frames, drop break/extended codes, publish make codes.
// Latency: sample/frame_error rise the cycle after the stop-bit fall (or after timeout).
// Backpressure: none; the consumer must take key_reg on the sample strobe.
// Ports: clock/reset (sync, active-high), ps2_clk/ps2_data raw pins,
//        key_reg last make code, sample new-code strobe, frame_error error strobe.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = PS2_FILTER_LEN_DEF,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_reg,
  output logic       sample,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          fall, data;
  logic [1:0]    state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          brk_q, brk_d;
  logic [7:0]    key_q, key_d;
  logic          sample_q, sample_d;
  logic          ferr_q, ferr_d;
  logic          tmo_hit;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clock      (clock),
    .reset      (reset),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_data),
    .fall_o     (fall),
    .data_o     (data)
  );

  assign tmo_hit = (state_q != ST_IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    tmo_d     = tmo_q;
    brk_d     = brk_q;
    key_d     = key_q;
    sample_d  = 1'b0;
    ferr_d    = 1'b0;
    if (tmo_hit) begin
      // Timeout beats a coincident fall; partial byte discarded, break kept.
      state_d   = ST_IDLE;
      shift_d   = '0;
      bit_cnt_d = '0;
      tmo_d     = '0;
      ferr_d    = 1'b1;
    end else if (fall) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (!data) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {data, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = data;
          state_d  = ST_STOP;
        end
        default: begin  // ST_STOP
          state_d = ST_IDLE;
          if (data && (^shift_q ^ parity_q)) begin
            if (shift_q == PS2_BREAK) begin
              brk_d = 1'b1;
            end else if (shift_q == PS2_EXT) begin
              brk_d = brk_q;
            end else if (brk_q) begin
              brk_d = 1'b0;  // release code of a key: swallow it
            end else begin
              key_d    = shift_q;
              sample_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
      endcase
    end else if (state_q == ST_IDLE) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
      brk_q     <= 1'b0;
      key_q     <= 8'h00;
      sample_q  <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tmo_q     <= tmo_d;
      brk_q     <= brk_d;
      key_q     <= key_d;
      sample_q  <= sample_d;
      ferr_q    <= ferr_d;
    end
  end

  assign key_reg     = key_q;
  assign sample      = sample_q;
  assign frame_error = ferr_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: drives PS/2 frames on the pins, keeps a
// frame-level model (expected event queue + break flag + current key),
// and checks every strobe and key_reg on every cycle.
module tb_ps2_keyboard_rx;

  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT    = 500;
  localparam int HALF       = 20;   // ps2_clk half period in system clocks

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_reg;
  logic       sample;
  logic       frame_error;

  ps2_keyboard_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .key_reg     (key_reg),
    .sample      (sample),
    .frame_error (frame_error)
  );

  always #10 clock = ~clock;

  typedef struct {
    bit         is_err;
    logic [7:0] key;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] model_key = 8'h00;
  bit         model_brk = 1'b0;
  int         tests = 0;
  int         fails = 0;
  bit         glitch_win = 1'b0;
  int         fall_seen = 0;

  // Frame-level model: what a complete frame must produce.
  task automatic model_frame(input logic [7:0] b, input bit par_ok, input bit stop);
    ev_t e;
    if (!(par_ok && stop)) begin
      e.is_err = 1'b1; e.key = 8'h00; exp_q.push_back(e);
    end else if (b == 8'hF0) begin
      model_brk = 1'b1;
    end else if (b == 8'hE0) begin
      // prefix only
    end else if (model_brk) begin
      model_brk = 1'b0;
    end else begin
      e.is_err = 1'b0; e.key = b; exp_q.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    wait_cyc(HALF);
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit stop);
    logic par;
    par = (~^b) ^ flip_par;
    model_frame(b, !flip_par, stop);
    send_bits({stop, par, b, 1'b0}, 11);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic settle_and_check(input string name, input logic [7:0] lit_key);
    wait_cyc(3 * HALF);
    check({name, " pending events"}, exp_q.size(), 0);
    check({name, " key literal"}, {24'd0, key_reg}, {24'd0, lit_key});
  endtask

  // Per-cycle compare against the model.
  always @(negedge clock) begin
    if (!reset) begin
      ev_t e;
      tests++;
      if (sample && frame_error) begin
        fails++; $display("FAIL strobes: sample and frame_error both high");
      end
      if (sample) begin
        tests++;
        if (exp_q.size() == 0 || exp_q[0].is_err) begin
          fails++; $display("FAIL sample: unexpected strobe, key_reg %0h", key_reg);
        end else begin
          e = exp_q.pop_front();
          model_key = e.key;
        end
      end
      if (frame_error) begin
        tests++;
        if (exp_q.size() == 0 || !exp_q[0].is_err) begin
          fails++; $display("FAIL frame_error: unexpected strobe, queued %0d", exp_q.size());
        end else begin
          e = exp_q.pop_front();
        end
      end
      if (key_reg !== model_key) begin
        fails++; $display("FAIL key_reg: got %0h, required %0h", key_reg, model_key);
      end
      if (glitch_win && dut.fall) fall_seen++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    wait_cyc(5);
    check("reset key_reg", {24'd0, key_reg}, 32'h0);
    check("reset sample", {31'd0, sample}, 32'h0);
    check("reset frame_error", {31'd0, frame_error}, 32'h0);
    reset = 1'b0;
    wait_cyc(5);

    // Valid make code
    send_frame(8'h1C, 1'b0, 1'b1);
    settle_and_check("make 1C", 8'h1C);

    // Break sequence swallowed, then a new make code
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    settle_and_check("break 1C", 8'h1C);
    send_frame(8'h32, 1'b0, 1'b1);
    settle_and_check("make 32", 8'h32);

    // Extended prefix ignored
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    settle_and_check("ext 75", 8'h75);

    // Bad parity, bad stop, then recovery
    send_frame(8'h1C, 1'b1, 1'b1);
    settle_and_check("bad parity", 8'h75);
    send_frame(8'h5A, 1'b0, 1'b0);
    settle_and_check("bad stop", 8'h75);
    send_frame(8'h1B, 1'b0, 1'b1);
    settle_and_check("make 1B", 8'h1B);

    // Break pending survives a timeout
    send_frame(8'hF0, 1'b0, 1'b1);
    begin
      ev_t e;
      e.is_err = 1'b1; e.key = 8'h00; exp_q.push_back(e);
    end
    send_bits({7'h00, 4'b1010}, 5);   // start + 4 data bits, then silence
    wait_cyc(TIMEOUT + 50);
    check("timeout pending events", exp_q.size(), 0);
    send_frame(8'h44, 1'b0, 1'b1);    // release code consumed by pending break
    settle_and_check("break after timeout", 8'h1B);
    send_frame(8'h2D, 1'b0, 1'b1);
    settle_and_check("make 2D", 8'h2D);

    // Reset mid-frame, then a short glitch on ps2_clk
    send_bits({7'h00, 4'b0110}, 4);
    reset = 1'b1;
    exp_q.delete();
    model_key = 8'h00;
    model_brk = 1'b0;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(2);
    check("post-reset key_reg", {24'd0, key_reg}, 32'h0);
    glitch_win = 1'b1;
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(20);
    glitch_win = 1'b0;
    check("glitch fall count", fall_seen, 0);
    check("glitch key_reg", {24'd0, key_reg}, 32'h0);
    check("glitch sample", {31'd0, sample}, 32'h0);
    send_frame(8'h29, 1'b0, 1'b1);
    settle_and_check("make 29", 8'h29);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

PS/2 keyboard receiver sitting directly upstream of the processor's memory block. It deserialises keyboard frames from the PS/2 clock/data pins and filters out break (key-release) and extended-prefix codes. For every accepted make code it presents the scan code on `key_reg` together with a one-cycle `sample` strobe, which the memory block's memory-mapped keyboard register consumes.

## Interface
- `FILTER_LEN`, 4: number of consecutive identical synchronised `ps2_clk` samples required before the filtered clock changes level.
- `TIMEOUT_CYCLES`, 50000: number of idle cycles mid-frame before the frame is aborted (1 ms at 50 MHz).
- `clock`  in  1: system clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `ps2_clk`  in  1: raw PS/2 clock pin; asynchronous.
- `ps2_data`  in  1: raw PS/2 data pin; asynchronous.
- `key_reg`  out  8: last accepted make scan code; held until the next accepted code.
- `sample`  out  1: one-cycle strobe, high in the cycle `key_reg` takes a new value.
- `frame_error`  out  1: one-cycle strobe on a parity, stop-bit or timeout error.

## Operation
- **Input conditioning.** `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser. The synchronised clock is filtered: the filtered level changes only after `FILTER_LEN` consecutive equal samples. `fall` pulses for one cycle when the filtered level goes 1→0. Data is taken from synchronised `ps2_data` in the `fall` cycle.
- **Frame format.** Start bit (0), 8 data bits LSB first, odd parity, stop bit (1).
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0, go to DATA and clear the bit count. On `fall` with data=1, ignore and stay in IDLE.
  - DATA: on each `fall`, shift the bit in at the MSB end (right shift). After the 8th bit, go to PARITY.
  - PARITY: on `fall`, store the parity bit and go to STOP.
  - STOP: on `fall`, return to IDLE. The frame is valid only if data=1 and (^byte ^ parity)=1. Otherwise pulse `frame_error`.
- **Valid byte handling:**
  - 0xF0: set `break_pending`. No `sample`.
  - 0xE0: ignored. No `sample`, `break_pending` unchanged.
  - Any other byte with `break_pending`=1: clear `break_pending`. No `sample`, `key_reg` unchanged.
  - Any other byte with `break_pending`=0: load `key_reg` and pulse `sample`.
- **Timeout.** The counter runs only outside IDLE, clears on every `fall`, and is `$clog2(TIMEOUT_CYCLES+1)` bits wide. On reaching `TIMEOUT_CYCLES`: go to IDLE, pulse `frame_error`, discard the partial byte. `break_pending` is kept.
- **Invalid frame.** No change to `key_reg` or `break_pending`.

## Timing
- Reset values: `key_reg`=0x00, `sample`=0, `frame_error`=0, state=IDLE, `break_pending`=0, shift register=0, bit count=0, timeout counter=0, filtered clock=1, synchroniser flops=1.
- `fall` is asserted 2 + `FILTER_LEN` cycles after a clean falling edge on the raw `ps2_clk` pin.
- `sample` and `frame_error` are registered. Each is high in the cycle after the `fall` cycle of the stop bit (or the cycle after the timeout is reached), and for exactly one cycle.
- `key_reg` updates on the same clock edge that raises `sample`. It is stable whenever `sample`=1.
- `sample` and `frame_error` are never high together.
- Reset mid-frame aborts the frame; no strobe is emitted. Reset has priority over every other event.
- A `fall` in the same cycle the timeout is reached: the timeout wins and the edge is dropped.
- Back-to-back frames: a start bit received on the cycle after STOP is accepted normally.

## Structure
- Package `ps2_pkg`: FSM state encoding, `PS2_BREAK`=8'hF0, `PS2_EXT`=8'hE0, default filter and timeout constants.
- Sub-module `ps2_clk_filter`: 2-FF synchroniser, `FILTER_LEN` filter, and `fall` edge detector for `ps2_clk`. It also outputs synchronised `ps2_data`, so both signals are delayed equally.
- Top level holds the FSM, shift register, parity check, timeout counter and code filter.

## Test plan
- Frame 0x1C with parity 0 (ps2_clk period 20 µs, clock 50 MHz) → one `sample` pulse, `key_reg`=0x1C, `frame_error`=0.
- Frames 0xF0 then 0x1C → no `sample`, `key_reg` unchanged. A following 0x32 → `sample` pulse, `key_reg`=0x32.
- Frames 0xE0 then 0x75 → exactly one `sample`, `key_reg`=0x75.
- Frame 0x1C with parity 1 → one `frame_error` pulse, no `sample`. A following valid 0x1B → `key_reg`=0x1B.
- Frame stopped after 4 data bits, idle for `TIMEOUT_CYCLES` → one `frame_error` pulse, FSM back in IDLE. A following valid 0x2D → `key_reg`=0x2D.
- `reset` asserted mid-frame, then a 3-cycle glitch on `ps2_clk` with `FILTER_LEN`=4 → no `fall`, outputs stay at reset values. A following valid 0x29 → `key_reg`=0x29.
